// File: rtl/conv_window_gen.sv
// Sliding K_SIZE x K_SIZE window generator for a raster-order pixel stream.
// K_SIZE-1 line buffers feed the newest column; the window register is also the output stage.
module conv_window_gen #(
  parameter int K_SIZE = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DW     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [K_SIZE*K_SIZE*DW-1:0] window_out
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NB = K_SIZE - 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_START = CW'(K_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_START = RW'(K_SIZE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic [DW-1:0] lbuf    [NB][IMG_W];
  logic [DW-1:0] new_col [K_SIZE];

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Buffer 0 holds the oldest row, so the new column reads top to bottom, newest pixel last.
  always_comb begin
    for (int i = 0; i < K_SIZE; i++) begin
      new_col[i] = in_data;
    end
    for (int i = 0; i < NB; i++) begin
      new_col[i] = lbuf[i][col];
    end
  end

  // Line buffers are never reset; rows with stale contents are never flagged valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < NB - 1; b++) begin
        lbuf[b][col] <= lbuf[b+1][col];
      end
      lbuf[NB-1][col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      window_out <= '0;
    end else if (accept) begin
      for (int i = 0; i < K_SIZE; i++) begin
        for (int j = 0; j < K_SIZE - 1; j++) begin
          window_out[(i*K_SIZE+j)*DW +: DW] <= window_out[(i*K_SIZE+j+1)*DW +: DW];
        end
        window_out[(i*K_SIZE+K_SIZE-1)*DW +: DW] <= new_col[i];
      end
      out_valid <= (row >= ROW_START) && (col >= COL_START);
      out_last  <= (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: coordinate-based window model with a scoreboard queue,
// plus a table of hand-computed window elements.
module tb_conv_window_gen;

  localparam int K     = 5;
  localparam int W     = 28;
  localparam int H     = 28;
  localparam int DW    = 16;
  localparam int WB    = K * K * DW;
  localparam int FRAME = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [WB-1:0] window_out;

  always #5 clk = ~clk;

  conv_window_gen #(.K_SIZE(K), .IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .window_out (window_out)
  );

  typedef struct {
    logic [WB-1:0] win;
    logic          last;
  } exp_t;

  typedef struct {
    int            phase;
    int            idx;
    int            i;
    int            j;
    logic [DW-1:0] val;
  } vec_t;

  exp_t          sb[$];
  logic [WB-1:0] got_win[$];
  logic          got_last[$];
  vec_t          vecs[12];

  int checks = 0;
  int fails  = 0;
  int sent, total, pr, pc, fidx, first_valid_at, stall_cnt;
  int bubble_pct, ready_pct;
  bit stall_mode, in_stall;

  function automatic logic [DW-1:0] pix(int fi, int r, int c);
    return DW'(fi * 4096 + r * W + c);
  endfunction

  // Window whose bottom-right pixel sits at (r, c) of frame fi.
  function automatic logic [WB-1:0] modelWin(int fi, int r, int c);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = pix(fi, r - (K-1) + i, c - (K-1) + j);
    return w;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkWin(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    in_stall = 1'b0;
    if (sent < total && $urandom_range(99) >= bubble_pct) begin
      in_valid = 1'b1;
      in_data  = pix(fidx, pr, pc);
    end else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
    if (stall_mode && out_valid && stall_cnt < 10) begin
      out_ready = 1'b0;
      stall_cnt++;
      in_stall  = 1'b1;
    end else begin
      out_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (out_valid && first_valid_at < 0) first_valid_at = sent;
    if (in_stall) begin
      checkVal("in_ready during stall", in_ready, 0);
      if (sb.size() > 0) checkWin("window held during stall", window_out, sb[0].win);
    end
    if (out_valid && out_ready) begin
      got_win.push_back(window_out);
      got_last.push_back(out_last);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected window #%0d: got %h, expected none", got_win.size() - 1, window_out);
      end else begin
        e = sb.pop_front();
        checkWin($sformatf("window #%0d", got_win.size() - 1), window_out, e.win);
        checkVal($sformatf("out_last #%0d", got_win.size() - 1), out_last, e.last);
      end
    end
  endtask

  task automatic runStream(input int nframes, input int limit, input int bub, input int rdy, input bit stall);
    exp_t e;
    bit   done;
    sent = 0;
    total = (limit > 0) ? limit : nframes * FRAME;
    pr = 0; pc = 0; fidx = 0;
    first_valid_at = -1;
    stall_cnt = 0;
    stall_mode = stall;
    bubble_pct = bub;
    ready_pct = rdy;
    sb.delete();
    got_win.delete();
    got_last.delete();
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      applyStimulus();
      #1;
      checkOutput();
      if (in_valid && in_ready) begin
        if (pr >= K-1 && pc >= K-1) begin
          e.win  = modelWin(fidx, pr, pc);
          e.last = (pr == H-1) && (pc == W-1);
          sb.push_back(e);
        end
        sent++;
        pc++;
        if (pc == W) begin
          pc = 0;
          pr++;
          if (pr == H) begin
            pr = 0;
            fidx++;
          end
        end
      end
      if (sent == total && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL stream timeout: sent %0d of %0d, %0d windows pending", sent, total, sb.size());
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    out_ready = 1'b0;
    #1;
    checkVal("in_ready while rst high", in_ready, 0);
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkVal("out_valid after reset", out_valid, 0);
    checkVal("out_last after reset", out_last, 0);
    checkWin("window_out after reset", window_out, '0);
  endtask

  task automatic runTable(input int phase);
    logic [WB-1:0] w;
    for (int n = 0; n < 12; n++) begin
      if (vecs[n].phase == phase) begin
        if (vecs[n].idx < got_win.size()) begin
          w = got_win[vecs[n].idx];
          checkVal($sformatf("table p%0d win%0d [%0d][%0d]", phase, vecs[n].idx, vecs[n].i, vecs[n].j),
                   w[(vecs[n].i*K+vecs[n].j)*DW +: DW], vecs[n].val);
        end else begin
          checks++;
          fails++;
          $display("[TB] FAIL table p%0d win%0d: got %0d windows, expected more", phase, vecs[n].idx, got_win.size());
        end
      end
    end
  endtask

  task automatic countLasts(input int expected);
    int n;
    n = 0;
    foreach (got_last[k]) if (got_last[k]) n++;
    checkVal("out_last count", n, expected);
  endtask

  initial begin
    vecs[0]  = '{0, 0,    0, 0, 16'h0000};
    vecs[1]  = '{0, 0,    0, 4, 16'h0004};
    vecs[2]  = '{0, 0,    4, 0, 16'h0070};
    vecs[3]  = '{0, 0,    4, 4, 16'h0074};
    vecs[4]  = '{0, 575,  0, 0, 16'h029B};
    vecs[5]  = '{0, 575,  4, 4, 16'h030F};
    vecs[6]  = '{0, 576,  0, 0, 16'h1000};
    vecs[7]  = '{0, 576,  4, 4, 16'h1074};
    vecs[8]  = '{0, 1151, 4, 4, 16'h130F};
    vecs[9]  = '{1, 0,    0, 0, 16'h0000};
    vecs[10] = '{1, 0,    4, 4, 16'h0074};
    vecs[11] = '{1, 575,  4, 4, 16'h030F};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    doReset(2);

    $display("[TB] two back-to-back frames, continuous flow");
    runStream(2, 0, 0, 100, 1'b0);
    checkVal("pixels before first out_valid", first_valid_at, 117);
    checkVal("window count two frames", got_win.size(), 1152);
    countLasts(2);
    if (got_last.size() > 1151) begin
      checkVal("out_last on window 575", got_last[575], 1);
      checkVal("out_last on window 1151", got_last[1151], 1);
    end
    runTable(0);

    $display("[TB] ten-cycle output stall");
    doReset(1);
    runStream(1, 0, 0, 100, 1'b1);
    checkVal("stall cycles applied", stall_cnt, 10);
    checkVal("window count with stall", got_win.size(), 576);

    $display("[TB] random bubbles and backpressure");
    doReset(1);
    runStream(1, 0, 30, 70, 1'b0);
    checkVal("window count random flow", got_win.size(), 576);
    countLasts(1);

    $display("[TB] reset after 50 pixels");
    doReset(1);
    runStream(0, 50, 0, 100, 1'b0);
    checkVal("windows in partial frame", got_win.size(), 0);
    doReset(1);
    runStream(1, 0, 0, 100, 1'b0);
    checkVal("pixels before first out_valid after reset", first_valid_at, 117);
    checkVal("window count after reset", got_win.size(), 576);
    runTable(1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
